uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_rx_cfg.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchroniser, 3-sample majority vote,
// optional parity, 1 or 2 stop bits, frame/break detection.
module uart_rx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 i_clock,
  input  logic                 i_rst_n,
  input  logic                 i_Rx_serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_CLEANUP
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic [2:0]           hist_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 brkw_q, brkw_d;
  logic                 dv_q, dv_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 perr_o_q, perr_o_d;
  logic                 ferr_o_q, ferr_o_d;
  logic                 brk_o_q, brk_o_d;

  logic vote, at_half, at_last, par_x, fe_now, brk_now;

  assign vote    = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
  assign at_half = (cnt_q == CNT_HALF);
  assign at_last = (cnt_q == CNT_LAST);
  assign par_x   = (^shift_q) ^ vote;
  assign fe_now  = ferr_q | ~vote;
  assign brk_now = (shift_q == '0) && fe_now;

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (!brkw_q && !sync2_q) state_d = S_START;
      S_START:   if (at_half) state_d = vote ? S_IDLE : S_DATA;
      S_DATA:    if (at_last && idx_q == IDX_LAST) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY:  if (at_last) state_d = S_STOP;
      S_STOP:    if (at_last && stop_q == STOP_LAST) state_d = S_CLEANUP;
      S_CLEANUP: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    stop_d   = stop_q;
    shift_d  = shift_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    brkw_d   = brkw_q;
    dv_d     = 1'b0;
    byte_d   = byte_q;
    perr_o_d = perr_o_q;
    ferr_o_d = ferr_o_q;
    brk_o_d  = brk_o_q;
    if (state_q == S_IDLE || state_d != state_q || at_last) cnt_d = '0;
    case (state_q)
      S_IDLE: if (brkw_q && sync2_q) brkw_d = 1'b0;
      S_START: begin
        if (at_half && !vote) begin
          idx_d  = '0;
          stop_d = 1'b0;
          perr_d = 1'b0;
          ferr_d = 1'b0;
        end
      end
      S_DATA: begin
        if (at_last) begin
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 1'b1;
        end
      end
      S_PARITY: if (at_last) perr_d = (PARITY == 1) ? ~par_x : par_x;
      S_STOP: begin
        if (at_last) begin
          ferr_d = fe_now;
          if (stop_q == STOP_LAST) begin
            // Results latch on the final stop vote so the receiver re-arms mid-bit.
            dv_d     = 1'b1;
            byte_d   = shift_q;
            perr_o_d = (PARITY != 0) && perr_q;
            ferr_o_d = fe_now;
            brk_o_d  = brk_now;
            brkw_d   = brk_now;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      hist_q   <= '1;
      cnt_q    <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      shift_q  <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      brkw_q   <= 1'b0;
      dv_q     <= 1'b0;
      byte_q   <= '0;
      perr_o_q <= 1'b0;
      ferr_o_q <= 1'b0;
      brk_o_q  <= 1'b0;
    end else begin
      sync1_q  <= i_Rx_serial;
      sync2_q  <= sync1_q;
      hist_q   <= {hist_q[1:0], sync2_q};
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      shift_q  <= shift_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      brkw_q   <= brkw_d;
      dv_q     <= dv_d;
      byte_q   <= byte_d;
      perr_o_q <= perr_o_d;
      ferr_o_q <= ferr_o_d;
      brk_o_q  <= brk_o_d;
    end
  end

  always_comb begin
    o_Busy       = (state_q != S_IDLE);
    o_Rx_DV      = dv_q;
    o_Rx_byte    = byte_q;
    o_Parity_Err = perr_o_q;
    o_Frame_Err  = ferr_o_q;
    o_Break      = brk_o_q;
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three receivers (8N1, 8E1, 8N2) at 8 clocks/bit.
module tb_uart_rx_cfg;

  localparam int CPB = 8;

  typedef struct packed {
    logic [7:0] b;
    logic       pe;
    logic       fe;
    logic       brk;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       rx    [0:2];
  logic       dv    [0:2];
  logic [7:0] byte_o[0:2];
  logic       pe    [0:2];
  logic       fe    [0:2];
  logic       brk   [0:2];
  logic       busy  [0:2];

  int   errors = 0;
  int   checks = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  string tag[0:2] = '{"A8N1", "B8E1", "C8N2"};

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .i_clock(clk), .i_rst_n(rst_n), .i_Rx_serial(rx[0]), .o_Rx_DV(dv[0]),
    .o_Rx_byte(byte_o[0]), .o_Parity_Err(pe[0]), .o_Frame_Err(fe[0]),
    .o_Break(brk[0]), .o_Busy(busy[0]));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
    .i_clock(clk), .i_rst_n(rst_n), .i_Rx_serial(rx[1]), .o_Rx_DV(dv[1]),
    .o_Rx_byte(byte_o[1]), .o_Parity_Err(pe[1]), .o_Frame_Err(fe[1]),
    .o_Break(brk[1]), .o_Busy(busy[1]));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_c (
    .i_clock(clk), .i_rst_n(rst_n), .i_Rx_serial(rx[2]), .o_Rx_DV(dv[2]),
    .o_Rx_byte(byte_o[2]), .o_Parity_Err(pe[2]), .o_Frame_Err(fe[2]),
    .o_Break(brk[2]), .o_Busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int inst, input logic [7:0] b, input logic p, input logic f, input logic k);
    exp_t e;
    e = '{b: b, pe: p, fe: f, brk: k};
    case (inst)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int inst);
    case (inst)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic handle(input int inst);
    exp_t e;
    if (qsize(inst) == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected_dv: got pulse with byte 0x%0h expected no pulse", tag[inst], byte_o[inst]);
    end else begin
      case (inst)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("%s_byte", tag[inst]), 32'(byte_o[inst]), 32'(e.b));
      chk($sformatf("%s_parity_err", tag[inst]), 32'(pe[inst]), 32'(e.pe));
      chk($sformatf("%s_frame_err", tag[inst]), 32'(fe[inst]), 32'(e.fe));
      chk($sformatf("%s_break", tag[inst]), 32'(brk[inst]), 32'(e.brk));
    end
  endtask

  // Monitor: compares each DV pulse against the queue and checks the cycle after it.
  initial begin
    bit prev[0:2];
    prev = '{1'b0, 1'b0, 1'b0};
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (prev[i]) begin
          chk($sformatf("%s_dv_width", tag[i]), 32'(dv[i]), 32'd0);
          chk($sformatf("%s_busy_after_dv", tag[i]), 32'(busy[i]), 32'd0);
        end
        if (dv[i] === 1'b1) handle(i);
        prev[i] = (dv[i] === 1'b1);
      end
    end
  end

  task automatic drive(input int inst, input logic v, input int n);
    rx[inst] = v;
    repeat (n) @(negedge clk);
  endtask

  // spike >= 0 puts a one-cycle low pulse two cycles into that (high) data bit.
  task automatic frame(input int inst, input logic [7:0] d, input bit par_en, input logic pbit,
                       input int nstop, input logic stop2, input int spike);
    drive(inst, 1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      if (i == spike) begin
        drive(inst, 1'b1, 2);
        drive(inst, 1'b0, 1);
        drive(inst, 1'b1, CPB - 3);
      end else begin
        drive(inst, d[i], CPB);
      end
    end
    if (par_en) drive(inst, pbit, CPB);
    drive(inst, 1'b1, CPB);
    if (nstop == 2) drive(inst, stop2, CPB);
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = '{1'b1, 1'b1, 1'b1};
    repeat (3) @(negedge clk);
    chk("A_rst_dv", 32'(dv[0]), 32'd0);
    chk("A_rst_byte", 32'(byte_o[0]), 32'd0);
    chk("A_rst_parity_err", 32'(pe[0]), 32'd0);
    chk("A_rst_frame_err", 32'(fe[0]), 32'd0);
    chk("A_rst_break", 32'(brk[0]), 32'd0);
    chk("A_rst_busy", 32'(busy[0]), 32'd0);
    chk("B_rst_busy", 32'(busy[1]), 32'd0);
    chk("C_rst_busy", 32'(busy[2]), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0xA5
    push(0, 8'hA5, 1'b0, 1'b0, 1'b0);
    frame(0, 8'hA5, 1'b0, 1'b0, 1, 1'b1, -1);
    drive(0, 1'b1, 3 * CPB);

    // 8E1: 0x03 with wrong parity, then correct parity, then 0x07 with parity 1
    push(1, 8'h03, 1'b1, 1'b0, 1'b0);
    frame(1, 8'h03, 1'b1, 1'b1, 1, 1'b1, -1);
    drive(1, 1'b1, 2 * CPB);
    push(1, 8'h03, 1'b0, 1'b0, 1'b0);
    frame(1, 8'h03, 1'b1, 1'b0, 1, 1'b1, -1);
    drive(1, 1'b1, 2 * CPB);
    push(1, 8'h07, 1'b0, 1'b0, 1'b0);
    frame(1, 8'h07, 1'b1, 1'b1, 1, 1'b1, -1);
    drive(1, 1'b1, 2 * CPB);

    // 8N2: second stop bit low, then a clean frame
    push(2, 8'h5A, 1'b0, 1'b1, 1'b0);
    frame(2, 8'h5A, 1'b0, 1'b0, 2, 1'b0, -1);
    drive(2, 1'b1, 3 * CPB);
    push(2, 8'h5A, 1'b0, 1'b0, 1'b0);
    frame(2, 8'h5A, 1'b0, 1'b0, 2, 1'b1, -1);
    drive(2, 1'b1, 3 * CPB);

    // Break: line low for 12 bit times; exactly one frame expected
    push(0, 8'h00, 1'b0, 1'b1, 1'b1);
    drive(0, 1'b0, 12 * CPB);
    drive(0, 1'b1, 3 * CPB);
    chk("A_no_frame_after_break", 32'(qsize(0)), 32'd0);
    push(0, 8'h81, 1'b0, 1'b0, 1'b0);
    frame(0, 8'h81, 1'b0, 1'b0, 1, 1'b1, -1);
    drive(0, 1'b1, 3 * CPB);

    // 2-cycle glitch, then 0x55 with a one-cycle spike in bit 2
    drive(0, 1'b0, 2);
    drive(0, 1'b1, 3 * CPB);
    chk("A_no_frame_after_glitch", 32'(qsize(0)), 32'd0);
    push(0, 8'h55, 1'b0, 1'b0, 1'b0);
    frame(0, 8'h55, 1'b0, 1'b0, 1, 1'b1, 2);
    drive(0, 1'b1, 3 * CPB);

    // Reset pulsed during bit 4 of 0xF0: no pulse, then clean 0x3C
    drive(0, 1'b0, CPB);
    drive(0, 1'b0, 4 * CPB);
    drive(0, 1'b1, 3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("A_busy_in_reset", 32'(busy[0]), 32'd0);
    chk("A_dv_in_reset", 32'(dv[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b1, 3);
    drive(0, 1'b1, 3 * CPB);
    drive(0, 1'b1, CPB);
    drive(0, 1'b1, 2 * CPB);
    push(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    frame(0, 8'h3C, 1'b0, 1'b0, 1, 1'b1, -1);
    drive(0, 1'b1, 2 * CPB);

    // Back-to-back frames with zero idle time
    push(0, 8'h11, 1'b0, 1'b0, 1'b0);
    push(0, 8'h22, 1'b0, 1'b0, 1'b0);
    frame(0, 8'h11, 1'b0, 1'b0, 1, 1'b1, -1);
    frame(0, 8'h22, 1'b0, 1'b0, 1, 1'b1, -1);
    drive(0, 1'b1, 4 * CPB);

    chk("A_queue_drained", 32'(qsize(0)), 32'd0);
    chk("B_queue_drained", 32'(qsize(1)), 32'd0);
    chk("C_queue_drained", 32'(qsize(2)), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
